// File: rtl/mem_pkg.sv
// Shared encodings for the MEM-stage memory access unit.
// Size codes, FSM states and big-endian lane-select helpers.
package mem_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RD   = 2'd1,
      WR   = 2'd2,
      RESP = 2'd3
   } state_t;

   localparam logic [31:0] BYTE_MASK = 32'h0000_00FF;
   localparam logic [31:0] HALF_MASK = 32'h0000_FFFF;

   // Big-endian: byte offset k sits at bit 8*(3-k); (3-k) == ~k for two bits.
   function automatic logic [4:0] byte_shift(input logic [1:0] off);
      return {~off, 3'b000};
   endfunction

   function automatic logic [4:0] half_shift(input logic [1:0] off);
      return off[1] ? 5'd0 : 5'd16;
   endfunction

   // Encoding 11 behaves as a word.
   function automatic logic is_word(input logic [1:0] sz);
      return sz[1];
   endfunction

endpackage

// File: rtl/mem_load_align.sv
// Combinational lane extract with sign/zero extend, and store-lane merge.
// Zero latency; no flow control.
module mem_load_align
   import mem_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  offset,
   input  logic [1:0]  size,
   input  logic        is_unsigned,
   input  logic [31:0] wdata,
   output logic [31:0] load_data,
   output logic [31:0] merged
);

   logic [4:0]  sh;
   logic [31:0] mask;
   logic [31:0] lane;
   logic        sign;

   always_comb begin
      sh        = (size == SZ_BYTE) ? byte_shift(offset) : half_shift(offset);
      mask      = (size == SZ_BYTE) ? BYTE_MASK : HALF_MASK;
      lane      = (word >> sh) & mask;
      sign      = ~is_unsigned & ((size == SZ_BYTE) ? lane[7] : lane[15]);
      load_data = word;
      merged    = wdata;
      if (!is_word(size)) begin
         load_data = lane | (sign ? ~mask : 32'h0);
         merged    = (word & ~(mask << sh)) | ((wdata & mask) << sh);
      end
   end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store initiator with RMW sub-word stores; MEM_MISALIGN_TRAP_EN traps misaligned accesses.
// Latency: load/word store 2 cycles, sub-word store 3, misaligned trap 1.
// Backpressure: stall held while a request is pending until the one-cycle RESP.
module mem_access_unit
   import mem_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   input  logic        req_write,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        stall,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        misalign,
   output logic [31:0] mem_address,
   output logic [31:0] mem_wr_data,
   output logic        mem_MemWrite,
   output logic        mem_MemRead,
   input  logic [31:0] mem_read_data
);

   state_t      state, next_state;
   logic [31:0] addr_q, wdata_q, word_q;
   logic [1:0]  size_q;
   logic        unsigned_q, write_q, mis_q;
   logic        req_mis;
   logic [31:0] req_addr_al;
   logic [31:0] load_data, merged;

`ifdef MEM_MISALIGN_TRAP_EN
   assign req_mis     = ((req_size == SZ_HALF) && req_addr[0]) ||
                        (is_word(req_size) && (req_addr[1:0] != 2'b00));
   assign req_addr_al = req_addr;
`else
   assign req_mis = 1'b0;
   // Misaligned requests are silently pulled down to their natural boundary.
   always_comb begin
      req_addr_al = req_addr;
      if (req_size == SZ_HALF)
         req_addr_al[0] = 1'b0;
      else if (is_word(req_size))
         req_addr_al[1:0] = 2'b00;
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= next_state;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q     <= '0;
         wdata_q    <= '0;
         word_q     <= '0;
         size_q     <= '0;
         unsigned_q <= 1'b0;
         write_q    <= 1'b0;
         mis_q      <= 1'b0;
      end else begin
         if (state == IDLE && req_valid) begin
            addr_q     <= req_addr_al;
            wdata_q    <= req_wdata;
            size_q     <= req_size;
            unsigned_q <= req_unsigned;
            write_q    <= req_write;
            mis_q      <= req_mis;
         end
         if (state == RD)
            word_q <= mem_read_data;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (req_valid) begin
               if (req_mis)
                  next_state = RESP;
               else if (req_write && is_word(req_size))
                  next_state = WR;
               else
                  next_state = RD;
            end
         end
         RD:      next_state = write_q ? WR : RESP;
         WR:      next_state = RESP;
         default: next_state = IDLE;
      endcase
   end

   mem_load_align u_align (
      .word        (word_q),
      .offset      (addr_q[1:0]),
      .size        (size_q),
      .is_unsigned (unsigned_q),
      .wdata       (wdata_q),
      .load_data   (load_data),
      .merged      (merged)
   );

   // Strobes decode from state alone so async reset drops them immediately.
   always_comb begin
      mem_MemRead  = (state == RD);
      mem_MemWrite = (state == WR);
      mem_address  = {addr_q[31:2], 2'b00};
      mem_wr_data  = '0;
      resp_valid   = 1'b0;
      resp_rdata   = '0;
      misalign     = 1'b0;
      stall        = req_valid && (state != RESP);
      case (state)
         WR: mem_wr_data = is_word(size_q) ? wdata_q : merged;
         RESP: begin
            resp_valid = 1'b1;
            misalign   = mis_q;
            if (!write_q && !mis_q)
               resp_rdata = load_data;
         end
         default: ;
      endcase
   end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

MEM-stage initiator that drives the word-wide, big-endian data memory port (`address`, `wr_data`, `MemWrite`, `MemRead`, `read_data`). It turns pipeline load and store requests of byte, halfword or word size into memory transactions. Sub-word stores use read-modify-write. Load results are lane-extracted and sign- or zero-extended. The unit stalls the pipeline until each access completes.

## Interface
- No parameters; data and address are fixed at 32 bits.
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: memory request present; held stable while `stall`=1.
- `req_write` in 1: 1 = store, 0 = load.
- `req_size` in 2: 00 byte, 01 half, 10 word; 11 is treated as word.
- `req_unsigned` in 1: zero-extend the load (lbu/lhu).
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, right-justified.
- `stall` out 1: freeze the pipeline.
- `resp_valid` out 1: one-cycle completion pulse.
- `resp_rdata` out 32: extended load data; 0 for stores.
- `misalign` out 1: misaligned-access flag, qualified by `resp_valid`.
- `mem_address` out 32: word-aligned address to memory (bits [1:0] = 00).
- `mem_wr_data` out 32: full word to write.
- `mem_MemWrite` out 1: write strobe.
- `mem_MemRead` out 1: read strobe.
- `mem_read_data` in 32: combinational read data from memory.

## Operation
- **Latch.** In IDLE with `req_valid`=1, latch the request: addr, size, unsigned, write, wdata.
- **States.** IDLE, RD, WR, RESP.
  - Load: IDLE→RD→RESP.
  - Word store: IDLE→WR→RESP.
  - Byte/half store: IDLE→RD→WR→RESP.
  - RESP→IDLE unconditionally.
- **Strobes.**
  - `mem_MemRead`=1 only in RD; `mem_MemWrite`=1 only in WR. Never both high.
  - Both strobes decode from state only.
  - `mem_address` and `mem_wr_data` are stable for the whole strobe cycle.
- **RD.** Capture `mem_read_data` into the word register at the clock edge leaving RD.
- **Lane mapping (big-endian).**
  - Byte offset k occupies bits [31-8k -: 8].
  - Half offset 0 → [31:16]; half offset 2 → [15:0].
- **Load extract.** Select the lane, then sign-extend (`req_unsigned`=0) or zero-extend (`req_unsigned`=1) to 32 bits.
- **Store merge.** Replace the addressed lane of the captured word with `req_wdata[7:0]` or `req_wdata[15:0]`. Other lanes keep their captured values.
- **Word store.** Write `req_wdata` directly, with no read.
- **Stall.** `stall` = `req_valid` && state≠RESP. In RESP the pipeline advances, and the next request is seen in IDLE on the following cycle.
- **Misaligned access.** A half with addr[0]=1, or a word with addr[1:0]≠00 (behaviour set by macro, see Configuration).

## Timing
- **Reset values.** State IDLE. All outputs 0. Internal registers 0.
- **Latency**, counting cycle 0 as the IDLE cycle in which the request is first seen:
  - load: `resp_valid` in cycle 2;
  - word store: cycle 2;
  - sub-word store: cycle 3;
  - misaligned trap: cycle 1.
- **RESP cycle.** `resp_valid` is high for exactly one cycle. `resp_rdata` is valid in that cycle and 0 otherwise.
- **Reset mid-operation.** Asserting `rst_n`=0 in RD or WR deasserts the strobes immediately (asynchronously). A partially issued RMW never writes.
- **`req_valid` drop in IDLE.** No transaction starts. `req_valid` dropping mid-transaction is a protocol violation; the latched request completes regardless.
- **Alignment.** `mem_address` is always `latched_addr` & ~3.

## Configuration
- Macro: `MEM_MISALIGN_TRAP_EN`.
- **Defined:**
  - A misaligned request issues no memory strobes and goes IDLE→RESP.
  - In RESP: `resp_valid`=1, `misalign`=1, `resp_rdata`=0.
- **Undefined:**
  - `misalign` is tied to 0.
  - Offending low address bits are forced to alignment: half clears bit 0, word clears bits [1:0].
  - The access then proceeds normally.
- The port list is identical in both builds.

## Structure
- **Shared package `mem_pkg`:**
  - size encodings `SZ_BYTE`/`SZ_HALF`/`SZ_WORD`;
  - state enum `IDLE`/`RD`/`WR`/`RESP`;
  - lane-select helper constants.
- **Sub-module `mem_load_align`:** combinational lane extract plus sign/zero extend, and store-lane merge. It is shared by the load path and the RMW path.

## Test plan
All scenarios preload memory word 0x10 = 0x8899AABB.
- **lb 0x11:** `mem_MemRead` pulse in cycle 1 at address 0x10 → cycle 2 `resp_valid`, `resp_rdata`=0xFFFFFF99.
- **lbu 0x11** → 0x00000099. **lh 0x12** → 0xFFFFAABB. **lhu 0x10** → 0x00008899.
- **sb 0x13, wdata 0x000000CC:**
  - RD in cycle 1, WR in cycle 2 with `mem_wr_data`=0x8899AACC, `resp_valid` in cycle 3;
  - a readback lw returns 0x8899AACC.
- **sw 0x10, wdata 0x12345678:**
  - no `mem_MemRead`;
  - `mem_MemWrite` in cycle 1;
  - `stall` is high for cycles 0–1 and low in cycle 2.
- **lh 0x11 with `MEM_MISALIGN_TRAP_EN`:**
  - `resp_valid` with `misalign`=1 in cycle 1, and no strobes.
  - Without the macro: reads 0x10 and returns 0xFFFF8899.
- **sh 0x10 with `rst_n` pulsed low during WR:**
  - `mem_MemWrite` falls in the same cycle;
  - the memory word remains 0x8899AABB;
  - the unit is in IDLE with all outputs 0.
